alien_update_scheduler: RTL and testbench

Per-frame scheduler that shares the single alien update engine (movement/collision datapath behind `dynamics_top`) among the eight alien slots. On each vertical-blank tick it walks slots 0–7 in order and issues one MOVE or SPAWN operation per eligible slot over a valid/ready/done handshake. It paces movement by the selected level and spawns at most one alien per frame. It sits between the VGA timing (`vga_driver` frame tick) and the update engine, in the `clk_25mhz` domain.

---
 rtl/game_pkg.sv | 35 +++
 rtl/alien_update_scheduler_level_pacer.sv | 54 +++++
 rtl/alien_update_scheduler.sv | 155 +++++++++++++++
 tb/tb_alien_update_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions for the alien update scheduler: op encodings,
// level-to-period mapping, slot count and scheduler state type.
package game_pkg;

    localparam int ALIEN_SLOTS = 8;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_SPAWN = 2'b10;

    localparam logic [3:0] PERIOD_L0 = 4'd8;
    localparam logic [3:0] PERIOD_L1 = 4'd6;
    localparam logic [3:0] PERIOD_L2 = 4'd4;
    localparam logic [3:0] PERIOD_L3 = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT
    } sched_state_e;

    // Number of frames between move frames for a given difficulty level.
    function automatic logic [3:0] level_period(input logic [1:0] lvl);
        logic [3:0] p;
        case (lvl)
            2'd0:    p = PERIOD_L0;
            2'd1:    p = PERIOD_L1;
            2'd2:    p = PERIOD_L2;
            default: p = PERIOD_L3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/alien_update_scheduler_level_pacer.sv
// Frame pacing counters: decides on each accepted frame tick whether this
// frame moves aliens and whether a spawn may be offered.
module level_pacer
    import game_pkg::*;
#(
    parameter int SPAWN_FRAMES = 60
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic       i_tick,
    input  logic [1:0] i_level,
    input  logic       i_spawn_taken,
    output logic       o_move_frame,
    output logic       o_spawn_ok
);

    localparam int CW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES + 1) : 1;
    localparam logic [CW-1:0] SPAWN_RELOAD = CW'(SPAWN_FRAMES - 1);

    logic [3:0]    r_move_ctr;
    logic [CW-1:0] r_spawn_ctr;
    logic          r_move_frame;
    logic          r_spawn_ok;
    logic          w_move_now;
    logic          w_spawn_now;

    assign w_move_now  = (r_move_ctr == 4'd0);
    assign w_spawn_now = (r_spawn_ctr == '0);

    // Latch frame flags and step both counters on a tick; a taken spawn reloads the spawn gap.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            r_move_ctr   <= 4'd0;
            r_spawn_ctr  <= '0;
            r_move_frame <= 1'b0;
            r_spawn_ok   <= 1'b0;
        end else if (i_tick) begin
            r_move_frame <= w_move_now;
            r_move_ctr   <= w_move_now ? (level_period(i_level) - 4'd1)
                                       : (r_move_ctr - 4'd1);
            r_spawn_ok   <= w_spawn_now;
            if (!w_spawn_now) begin
                r_spawn_ctr <= r_spawn_ctr - CW'(1);
            end
        end else if (i_spawn_taken) begin
            r_spawn_ctr <= SPAWN_RELOAD;
            r_spawn_ok  <= 1'b0;
        end
    end

    assign o_move_frame = r_move_frame;
    assign o_spawn_ok   = r_spawn_ok;

endmodule

// File: rtl/alien_update_scheduler.sv
// Per-frame scheduler that walks the alien slots after each vblank tick and
// hands MOVE/SPAWN operations to the shared update engine one at a time.
module alien_update_scheduler
    import game_pkg::*;
#(
    parameter int NUM_ALIENS   = ALIEN_SLOTS,
    parameter int SPAWN_FRAMES = 60,
    localparam int SW = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1
) (
    input  logic                  clk_25mhz,
    input  logic                  reset,
    input  logic                  frame_tick,
    input  logic                  game_over,
    input  logic [1:0]            level,
    input  logic [NUM_ALIENS-1:0] alien_alive,
    output logic                  upd_valid,
    output logic [SW-1:0]         upd_slot,
    output logic [1:0]            upd_op,
    input  logic                  upd_ready,
    input  logic                  upd_done,
    output logic                  frame_busy,
    output logic                  overrun
);

    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_ALIENS - 1);

    sched_state_e  r_state;
    logic [SW-1:0] r_idx;
    logic          r_valid;
    logic [SW-1:0] r_slot;
    logic [1:0]    r_op;
    logic          r_busy;
    logic          r_overrun;

    sched_state_e  w_state;
    logic [SW-1:0] w_idx;
    logic          w_valid;
    logic [SW-1:0] w_slot;
    logic [1:0]    w_op;
    logic          w_busy;
    logic          w_overrun;
    logic          w_tick_accept;
    logic          w_spawn_taken;
    logic          w_move_frame;
    logic          w_spawn_ok;
    logic          w_last;

    level_pacer #(
        .SPAWN_FRAMES(SPAWN_FRAMES)
    ) u_pacer (
        .clk_25mhz    (clk_25mhz),
        .reset        (reset),
        .i_tick       (w_tick_accept),
        .i_level      (level),
        .i_spawn_taken(w_spawn_taken),
        .o_move_frame (w_move_frame),
        .o_spawn_ok   (w_spawn_ok)
    );

    assign w_last = (r_idx == LAST_SLOT);

    // Register the FSM state and every output so the engine sees glitch-free requests.
    always_ff @(posedge clk_25mhz or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_slot    <= '0;
            r_op      <= OP_NONE;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_idx     <= w_idx;
            r_valid   <= w_valid;
            r_slot    <= w_slot;
            r_op      <= w_op;
            r_busy    <= w_busy;
            r_overrun <= w_overrun;
        end
    end

    // Next-state logic: scan slots, issue one op per eligible slot, wait for the engine.
    always_comb begin
        w_state       = r_state;
        w_idx         = r_idx;
        w_valid       = r_valid;
        w_slot        = r_slot;
        w_op          = r_op;
        w_overrun     = r_overrun;
        w_tick_accept = 1'b0;
        w_spawn_taken = 1'b0;

        if (frame_tick && (r_state != ST_IDLE)) begin
            w_overrun = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (frame_tick && !game_over) begin
                    w_tick_accept = 1'b1;
                    w_idx         = '0;
                    w_state       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (alien_alive[r_idx] && w_move_frame) begin
                    w_valid = 1'b1;
                    w_slot  = r_idx;
                    w_op    = OP_MOVE;
                    w_state = ST_ISSUE;
                end else if (!alien_alive[r_idx] && w_spawn_ok) begin
                    w_valid = 1'b1;
                    w_slot  = r_idx;
                    w_op    = OP_SPAWN;
                    w_state = ST_ISSUE;
                end else if (w_last) begin
                    w_state = ST_IDLE;
                end else begin
                    w_idx = r_idx + SW'(1);
                end
            end
            ST_ISSUE: begin
                if (r_valid && upd_ready) begin
                    w_valid       = 1'b0;
                    w_op          = OP_NONE;
                    w_spawn_taken = (r_op == OP_SPAWN);
                    w_state       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (upd_done) begin
                    if (w_last) begin
                        w_state = ST_IDLE;
                    end else begin
                        w_idx   = r_idx + SW'(1);
                        w_state = ST_SCAN;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase

        w_busy = (w_state != ST_IDLE);
    end

    assign upd_valid  = r_valid;
    assign upd_slot   = r_slot;
    assign upd_op     = r_op;
    assign frame_busy = r_busy;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_alien_update_scheduler.sv
// Self-checking bench for alien_update_scheduler: directed frame table,
// hand-written corner sequences and randomized frames against a frame-level model.
module tb_alien_update_scheduler;

    localparam int SPAWN_F = 4;
    localparam int T_MOVE  = 1;
    localparam int T_SPAWN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       game_over;
    logic [1:0] level;
    logic [7:0] alien_alive;
    logic       upd_valid;
    logic [2:0] upd_slot;
    logic [1:0] upd_op;
    logic       upd_ready;
    logic       upd_done;
    logic       frame_busy;
    logic       overrun;

    always #5 clk = ~clk;

    alien_update_scheduler #(
        .NUM_ALIENS  (8),
        .SPAWN_FRAMES(SPAWN_F)
    ) dut (
        .clk_25mhz  (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .game_over  (game_over),
        .level      (level),
        .alien_alive(alien_alive),
        .upd_valid  (upd_valid),
        .upd_slot   (upd_slot),
        .upd_op     (upd_op),
        .upd_ready  (upd_ready),
        .upd_done   (upd_done),
        .frame_busy (frame_busy),
        .overrun    (overrun)
    );

    int vecCount  = 0;
    int missCount = 0;

    // Engine model state
    int         readyDelay    = 0;
    int         doneLat       = 1;
    int         waitCnt       = 0;
    int         doneCountdown = 0;
    bit         engineReset   = 1'b1;
    int         issuedQ[$];
    logic [2:0] seenSlot;
    logic [1:0] seenOp;

    // Frame-level reference model state
    int mTick      = 0;
    int mNextMove  = 0;
    int mNextSpawn = 0;
    int expQ[$];
    bit expOvr     = 1'b0;

    typedef struct {
        logic [7:0] alive;
        logic [1:0] lvl;
        bit         go;
        int         expOps;
        int         expSpawn;
    } vec_t;

    vec_t vecTable[12];

    task automatic checkOutput(input string name, input logic signed [31:0] actual,
                               input logic signed [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Update engine: accepts after readyDelay cycles of valid, pulses done doneLat cycles later.
    initial begin
        upd_ready = 1'b0;
        upd_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (engineReset) begin
                upd_ready     = 1'b0;
                upd_done      = 1'b0;
                waitCnt       = 0;
                doneCountdown = 0;
            end else begin
                upd_done = 1'b0;
                if (doneCountdown > 0) begin
                    doneCountdown--;
                    if (doneCountdown == 0) upd_done = 1'b1;
                end
                if (upd_ready) begin
                    issuedQ.push_back(int'(seenSlot) * 4 + int'(seenOp));
                    upd_ready = 1'b0;
                    waitCnt   = 0;
                    if (doneLat <= 1) upd_done = 1'b1;
                    else doneCountdown = doneLat - 1;
                end else if (upd_valid) begin
                    seenSlot = upd_slot;
                    seenOp   = upd_op;
                    if (waitCnt >= readyDelay) upd_ready = 1'b1;
                    else waitCnt++;
                end
            end
        end
    end

    // Expected op list for one accepted frame, from the pacing rules in frame numbers.
    task automatic modelFrame(input logic [7:0] alive, input logic [1:0] lvl);
        bit mv;
        bit sp;
        expQ.delete();
        mTick++;
        mv = (mTick >= mNextMove);
        if (mv) mNextMove = mTick + (8 - 2 * int'(lvl));
        sp = (mTick >= mNextSpawn);
        for (int i = 0; i < 8; i++) begin
            if (alive[i]) begin
                if (mv) expQ.push_back(i * 4 + T_MOVE);
            end else if (sp) begin
                expQ.push_back(i * 4 + T_SPAWN);
                sp         = 1'b0;
                mNextSpawn = mTick + SPAWN_F;
            end
        end
    endtask

    task automatic applyReset(input string tag);
        reset       = 1'b0;
        engineReset = 1'b1;
        frame_tick  = 1'b0;
        game_over   = 1'b0;
        #1;
        checkOutput({tag, " rst_valid"}, upd_valid, 0);
        checkOutput({tag, " rst_slot"}, upd_slot, 0);
        checkOutput({tag, " rst_op"}, upd_op, 0);
        checkOutput({tag, " rst_busy"}, frame_busy, 0);
        checkOutput({tag, " rst_overrun"}, overrun, 0);
        mTick      = 0;
        mNextMove  = 0;
        mNextSpawn = 0;
        expOvr     = 1'b0;
        repeat (2) @(negedge clk);
        reset       = 1'b1;
        engineReset = 1'b0;
        @(negedge clk);
    endtask

    // Wait for the frame to end (bounded), then compare issued ops against the model.
    task automatic finishFrame(input string tag, input int startBusy);
        int busyCycles;
        bit ended;
        busyCycles = startBusy;
        ended      = 1'b0;
        for (int k = 0; k < 3000 && !ended; k++) begin
            @(negedge clk);
            frame_tick = 1'b0;
            if (frame_busy) busyCycles++;
            else ended = 1'b1;
        end
        checkOutput({tag, " frame_end"}, ended, 1);
        if (expQ.size() == 0) checkOutput({tag, " idle_len"}, busyCycles, 8);
        checkOutput({tag, " op_count"}, issuedQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            checkOutput($sformatf("%s op%0d", tag, i),
                        (i < issuedQ.size()) ? issuedQ[i] : -1, expQ[i]);
        end
        checkOutput({tag, " overrun"}, overrun, expOvr);
    endtask

    // One frame: drive inputs, pulse the tick, optionally disturb mid-frame, then check.
    task automatic applyStimulus(input logic [7:0] alive, input logic [1:0] lvl, input bit go,
                                 input bit goMid, input bit extraTick, input string tag,
                                 output int nOps);
        alien_alive = alive;
        level       = lvl;
        game_over   = go;
        issuedQ.delete();
        if (go) expQ.delete();
        else modelFrame(alive, lvl);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        if (go) begin
            repeat (4) @(negedge clk);
            checkOutput({tag, " blocked_busy"}, frame_busy, 0);
            checkOutput({tag, " blocked_ops"}, issuedQ.size(), 0);
            checkOutput({tag, " overrun"}, overrun, expOvr);
        end else begin
            checkOutput({tag, " busy_rise"}, frame_busy, 1);
            if (goMid) game_over = 1'b1;
            if (extraTick) begin
                frame_tick = 1'b1;
                expOvr     = 1'b1;
            end
            finishFrame(tag, 1);
        end
        nOps = issuedQ.size();
    endtask

    function automatic int spawnSlot();
        int s;
        s = -1;
        foreach (issuedQ[i]) if ((issuedQ[i] % 4) == T_SPAWN) s = issuedQ[i] / 4;
        return s;
    endfunction

    initial begin
        int   nOps;
        bit   seen;
        int   s0;
        int   o0;

        vecTable[0]  = '{8'hF5, 2'd0, 1'b0, 7, 1};
        vecTable[1]  = '{8'hF5, 2'd0, 1'b0, 0, -1};
        vecTable[2]  = '{8'hF5, 2'd0, 1'b0, 0, -1};
        vecTable[3]  = '{8'hF5, 2'd0, 1'b0, 0, -1};
        vecTable[4]  = '{8'hF5, 2'd0, 1'b0, 1, 1};
        vecTable[5]  = '{8'hFF, 2'd0, 1'b0, 0, -1};
        vecTable[6]  = '{8'hFF, 2'd0, 1'b0, 0, -1};
        vecTable[7]  = '{8'hFF, 2'd0, 1'b0, 0, -1};
        vecTable[8]  = '{8'hFF, 2'd0, 1'b0, 8, -1};
        vecTable[9]  = '{8'h00, 2'd3, 1'b0, 1, 0};
        vecTable[10] = '{8'h00, 2'd3, 1'b1, 0, -1};
        vecTable[11] = '{8'hFF, 2'd3, 1'b0, 0, -1};

        reset       = 1'b1;
        frame_tick  = 1'b0;
        game_over   = 1'b0;
        level       = 2'd0;
        alien_alive = 8'h00;
        #2;
        @(negedge clk);
        applyReset("init");

        // Directed frame table
        readyDelay = 1;
        doneLat    = 2;
        for (int v = 0; v < 12; v++) begin
            applyStimulus(vecTable[v].alive, vecTable[v].lvl, vecTable[v].go, 1'b0, 1'b0,
                          $sformatf("vec%0d", v), nOps);
            checkOutput($sformatf("vec%0d table_ops", v), nOps, vecTable[v].expOps);
            checkOutput($sformatf("vec%0d spawn_slot", v), spawnSlot(), vecTable[v].expSpawn);
        end

        // First-request latency and a 10-cycle ready stall
        applyReset("lat");
        readyDelay  = 10;
        doneLat     = 2;
        alien_alive = 8'h01;
        level       = 2'd0;
        issuedQ.delete();
        modelFrame(alien_alive, level);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("lat busy_t1", frame_busy, 1);
        checkOutput("lat valid_t1", upd_valid, 0);
        @(negedge clk);
        checkOutput("lat valid_t2", upd_valid, 1);
        checkOutput("lat slot_t2", upd_slot, 0);
        checkOutput("lat op_t2", upd_op, T_MOVE);
        s0 = int'(upd_slot);
        o0 = int'(upd_op);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("stall valid%0d", k), upd_valid, 1);
            checkOutput($sformatf("stall req%0d", k), int'(upd_slot) * 4 + int'(upd_op),
                        s0 * 4 + o0);
        end
        finishFrame("stall", 0);

        // Dropped tick while busy, then prove it did not advance the move pacing
        readyDelay = 0;
        doneLat    = 1;
        applyStimulus(8'hFF, 2'd0, 1'b0, 1'b0, 1'b1, "ovr", nOps);
        for (int f = 0; f < 7; f++) begin
            applyStimulus(8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, $sformatf("post_ovr%0d", f), nOps);
        end

        // game_over raised mid-frame, then a blocked tick
        applyStimulus(8'h0F, 2'd1, 1'b0, 1'b1, 1'b0, "go_mid", nOps);
        applyStimulus(8'h0F, 2'd1, 1'b1, 1'b0, 1'b0, "go_block", nOps);
        game_over = 1'b0;

        // Asynchronous reset while a request is pending
        applyReset("pre_issue");
        readyDelay  = 50;
        alien_alive = 8'hFF;
        frame_tick  = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        seen       = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = upd_valid;
        end
        checkOutput("issue reached", seen, 1);
        applyReset("in_issue");
        readyDelay = 0;

        // Randomized frames against the model
        for (int f = 0; f < 60; f++) begin
            readyDelay = $urandom_range(0, 3);
            doneLat    = $urandom_range(1, 3);
            applyStimulus(8'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                          1'b0, 1'b0, $sformatf("rnd%0d", f), nOps);
        end
        game_over = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
